// File: rtl/demux_16_sched.sv
// ----------------------------------------------------------------------------
// demux_16_sched
//
// Sequencing controller for a 16-bit 1-to-16 demultiplexer tree (1:2 first
// stage on sel_4, two 1:8 stages on sel_1..sel_3). Words arrive over a
// valid/ready handshake and go to an addressed or a round-robin destination.
// out_data and the selects settle for one cycle before a one-hot strobe
// lets only the chosen destination capture the word. Each destination has a
// pending flag that blocks a second word until dest_ack clears it.
//
// Ports
//   clk              single clock, rising edge
//   rst              synchronous, active-high reset
//   in_valid         upstream word available
//   in_ready         controller can accept (IDLE and not in reset)
//   in_data[15:0]    word to distribute
//   in_dest[3:0]     destination index, used when mode = 0
//   mode             0 = addressed, 1 = round-robin; sampled at accept
//   dest_ack[15:0]   bit i clears pending flag i
//   out_data[15:0]   demux data input
//   sel_1..sel_4     demux selects, sel_1 = d[0] ... sel_4 = d[3]
//   out_strobe[15:0] one-hot capture pulse for the chosen destination
//   pending[15:0]    destination i holds an unacknowledged word
//   delivered_count  total strobes issued, wraps at 16 bits
// ----------------------------------------------------------------------------
module demux_16_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic [3:0]  in_dest,
   input  logic        mode,
   input  logic [15:0] dest_ack,
   output logic [15:0] out_data,
   output logic        sel_1,
   output logic        sel_2,
   output logic        sel_3,
   output logic        sel_4,
   output logic [15:0] out_strobe,
   output logic [15:0] pending,
   output logic [15:0] delivered_count
);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StSetup,
      StStrobe
   } state_t;

   state_t      state;
   logic [15:0] word;       // word held while waiting for a free destination
   logic        word_mode;  // mode sampled at accept
   logic [3:0]  dest;       // resolved (or requested, while waiting) destination
   logic [3:0]  rr_ptr;     // round-robin search start
   logic [15:0] count;

   // Pending flags as they stand after this cycle's acks; every destination
   // decision is made against this view.
   logic [15:0] pend_clr;

   // Round-robin search result
   logic        rr_found;
   logic [3:0]  rr_idx;
   logic [3:0]  probe;

   // Destination resolution for the current cycle
   logic        cur_mode;
   logic [3:0]  cur_dest;
   logic        go;
   logic [3:0]  go_dest;

   assign pend_clr        = pending & ~dest_ack;
   assign in_ready        = (state == StIdle) && !rst;
   assign delivered_count = count;

   // First free destination at or after rr_ptr, wrapping modulo 16.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = rr_ptr;
      probe    = rr_ptr;
      for (int i = 0; i < 16; i++) begin
         probe = rr_ptr + 4'(i);
         if (!rr_found && !pend_clr[probe]) begin
            rr_found = 1'b1;
            rr_idx   = probe;
         end
      end
   end

   // In IDLE the request comes straight from the inputs; in WAIT it comes
   // from what was latched at accept.
   always_comb begin
      cur_mode = word_mode;
      cur_dest = dest;
      if (state == StIdle) begin
         cur_mode = mode;
         cur_dest = in_dest;
      end
      if (cur_mode) begin
         go      = rr_found;
         go_dest = rr_idx;
      end else begin
         go      = !pend_clr[cur_dest];
         go_dest = cur_dest;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         word       <= 16'h0000;
         word_mode  <= 1'b0;
         dest       <= 4'h0;
         rr_ptr     <= 4'h0;
         count      <= 16'h0000;
         out_data   <= 16'h0000;
         sel_1      <= 1'b0;
         sel_2      <= 1'b0;
         sel_3      <= 1'b0;
         sel_4      <= 1'b0;
         out_strobe <= 16'h0000;
         pending    <= 16'h0000;
      end else begin
         pending <= pend_clr;
         case (state)
            StIdle: begin
               if (in_valid) begin
                  word      <= in_data;
                  word_mode <= mode;
                  dest      <= in_dest;
                  if (go) begin
                     // Data and selects move only on entry to SETUP.
                     dest                         <= go_dest;
                     out_data                     <= in_data;
                     {sel_4, sel_3, sel_2, sel_1} <= go_dest;
                     state                        <= StSetup;
                  end else begin
                     state <= StWait;
                  end
               end
            end
            StWait: begin
               if (go) begin
                  dest                         <= go_dest;
                  out_data                     <= word;
                  {sel_4, sel_3, sel_2, sel_1} <= go_dest;
                  state                        <= StSetup;
               end
            end
            StSetup: begin
               out_strobe <= 16'h0001 << dest;
               state      <= StStrobe;
            end
            StStrobe: begin
               out_strobe <= 16'h0000;
               // Setting after the ack clear makes the set win on a collision.
               pending    <= pend_clr | out_strobe;
               count      <= count + 16'h0001;
               if (word_mode) begin
                  rr_ptr <= dest + 4'h1;
               end
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   // The strobe is one-hot, and the demux inputs never move under it.
   a_strobe_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(out_strobe));
   a_stable_under_strobe: assert property (@(posedge clk) disable iff (rst)
      (out_strobe != 16'h0000) |-> ($stable(out_data) && $stable({sel_4, sel_3, sel_2, sel_1})));

endmodule

// File: tb/tb_demux_16_sched.sv
// ----------------------------------------------------------------------------
// tb_demux_16_sched
//
// Scenario tasks drive demux_16_sched and compare its outputs with a
// behavioural model of the destination rules (pending set, round-robin
// pointer, strobe count) kept in plain variables.
// ----------------------------------------------------------------------------
module tb_demux_16_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_dest;
   logic        mode;
   logic [15:0] dest_ack;
   logic [15:0] out_data;
   logic        sel_1, sel_2, sel_3, sel_4;
   logic [15:0] out_strobe;
   logic [15:0] pending;
   logic [15:0] delivered_count;
   logic [3:0]  sels;

   assign sels = {sel_4, sel_3, sel_2, sel_1};

   demux_16_sched dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .in_dest         (in_dest),
      .mode            (mode),
      .dest_ack        (dest_ack),
      .out_data        (out_data),
      .sel_1           (sel_1),
      .sel_2           (sel_2),
      .sel_3           (sel_3),
      .sel_4           (sel_4),
      .out_strobe      (out_strobe),
      .pending         (pending),
      .delivered_count (delivered_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [15:0] m_pend;
   int          m_ptr;
   int          m_cnt;

   typedef struct {
      int          lat;          // cycles from offer to strobe, -1 on timeout
      int          acc_idx;      // cycle of accept, -1 if never
      int          ready_hi;     // in_ready=1 samples between accept and strobe
      logic [15:0] strobe;
      logic [3:0]  setup_sel;
      logic [15:0] setup_data;
      logic [15:0] setup_strobe;
      logic [3:0]  strobe_sel;
      logic [15:0] strobe_data;
      logic [15:0] pend_after;
      logic [15:0] cnt_after;
   } obs_t;

   // Destination chosen under the rules, or -1 when the word must wait.
   function automatic int predict(input logic m, input logic [3:0] dst,
                                  input logic [15:0] pend, input int ptr);
      if (!m) return pend[dst] ? -1 : int'(dst);
      for (int i = 0; i < 16; i++) begin
         if (!pend[(ptr + i) % 16]) return (ptr + i) % 16;
      end
      return -1;
   endfunction

   task automatic commit(input logic m, input int d);
      m_pend = m_pend | (16'h0001 << d);
      if (m) m_ptr = (d + 1) % 16;
      m_cnt = (m_cnt + 1) % 65536;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; dest_ack = 16'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      m_pend = 16'h0; m_ptr = 0; m_cnt = 0;
   endtask

   task automatic pulse_ack(input logic [15:0] mask);
      dest_ack = mask;
      @(negedge clk);
      dest_ack = 16'h0;
   endtask

   // Offers one word and observes it through to the strobe. ack_mask is
   // driven during cycle ack_idx (counted from the offer cycle). Returns one
   // cycle after the strobe, so back-to-back calls give peak throughput.
   task automatic send(input logic m, input logic [3:0] dst, input logic [15:0] data,
                       input int ack_idx, input logic [15:0] ack_mask, output obs_t o);
      logic [3:0]  psel;
      logic [15:0] pdata;
      logic [15:0] pstb;
      o.lat = -1; o.acc_idx = -1; o.ready_hi = 0; o.strobe = '0;
      o.setup_sel = '0; o.setup_data = '0; o.setup_strobe = '0;
      o.strobe_sel = '0; o.strobe_data = '0; o.pend_after = '0; o.cnt_after = '0;
      psel = '0; pdata = '0; pstb = '0;
      in_valid = 1'b1; mode = m; in_dest = dst; in_data = data;
      for (int k = 0; k < 40; k++) begin
         dest_ack = (k == ack_idx) ? ack_mask : 16'h0;
         if (o.acc_idx >= 0 && out_strobe != 16'h0) begin
            o.lat = k; o.strobe = out_strobe;
            o.setup_sel = psel; o.setup_data = pdata; o.setup_strobe = pstb;
            o.strobe_sel = sels; o.strobe_data = out_data;
            break;
         end
         if (o.acc_idx >= 0 && in_ready) o.ready_hi++;
         if (o.acc_idx < 0 && in_ready) o.acc_idx = k;
         psel = sels; pdata = out_data; pstb = out_strobe;
         @(negedge clk);
         if (o.acc_idx >= 0) in_valid = 1'b0;
      end
      @(negedge clk);
      dest_ack = 16'h0; in_valid = 1'b0;
      o.pend_after = pending; o.cnt_after = delivered_count;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; mode = 1'b0; in_dest = 4'h0; in_data = 16'h0;
      dest_ack = 16'h0;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
      end
      checks++;
      if ({out_data, sels, out_strobe, pending, delivered_count} !== 68'h0) begin
         failures++;
         $display("FAIL reset_outputs got data=%h sel=%h stb=%h pend=%h cnt=%h want all 0",
                  out_data, sels, out_strobe, pending, delivered_count);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_release_ready got=%b want=1", in_ready);
      end
      // Word to dest 5, then reset in the middle of its strobe cycle.
      in_valid = 1'b1; mode = 1'b0; in_dest = 4'd5; in_data = 16'h1234;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_strobe !== 16'h0020) begin
         failures++; $display("FAIL reset_pre_strobe got=%h want=0020", out_strobe);
      end
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (out_strobe !== 16'h0 || out_data !== 16'h0 || sels !== 4'h0 || pending !== 16'h0
             || delivered_count !== 16'h0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_strobe cyc=%0d got stb=%h data=%h sel=%h pend=%h cnt=%h rdy=%b want all 0",
                     k, out_strobe, out_data, sels, pending, delivered_count, in_ready);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++; $display("FAIL reset_mid_release_ready got=%b want=1", in_ready);
      end
      m_pend = 16'h0; m_ptr = 0; m_cnt = 0;
   endtask

   task automatic test_addressed_sweep();
      obs_t        o;
      int          e;
      logic [15:0] ack;
      logic [15:0] dat;
      do_reset();
      for (int d = 0; d < 16; d++) begin
         ack = (d > 0) ? (16'h0001 << (d - 1)) : 16'h0;
         dat = 16'hA000 + 16'(d);
         m_pend = m_pend & ~ack;
         e = predict(1'b0, 4'(d), m_pend, m_ptr);
         send(1'b0, 4'(d), dat, 0, ack, o);
         commit(1'b0, e);
         checks++;
         if (o.acc_idx !== 0 || o.lat !== 2) begin
            failures++;
            $display("FAIL sweep_timing d=%0d got acc=%0d lat=%0d want acc=0 lat=2", d, o.acc_idx, o.lat);
         end
         checks++;
         if (o.strobe !== (16'h0001 << e) || o.setup_strobe !== 16'h0) begin
            failures++;
            $display("FAIL sweep_strobe d=%0d got stb=%h setup_stb=%h want stb=%h setup_stb=0",
                     d, o.strobe, o.setup_strobe, 16'h0001 << e);
         end
         checks++;
         if (o.setup_sel !== 4'(e) || o.setup_data !== dat || o.strobe_sel !== 4'(e)
             || o.strobe_data !== dat) begin
            failures++;
            $display("FAIL sweep_sel_data d=%0d got sel=%h/%h data=%h/%h want sel=%h data=%h",
                     d, o.setup_sel, o.strobe_sel, o.setup_data, o.strobe_data, 4'(e), dat);
         end
         checks++;
         if (o.pend_after !== m_pend || o.cnt_after !== 16'(m_cnt)) begin
            failures++;
            $display("FAIL sweep_state d=%0d got pend=%h cnt=%h want pend=%h cnt=%h",
                     d, o.pend_after, o.cnt_after, m_pend, 16'(m_cnt));
         end
      end
      pulse_ack(16'h8000);
      m_pend = m_pend & ~16'h8000;
      checks++;
      if (pending !== m_pend || delivered_count !== 16'd16) begin
         failures++;
         $display("FAIL sweep_final got pend=%h cnt=%0d want pend=%h cnt=16",
                  pending, delivered_count, m_pend);
      end
   endtask

   task automatic test_addressed_block();
      obs_t o1;
      obs_t o2;
      int   e;
      do_reset();
      e = predict(1'b0, 4'd7, m_pend, m_ptr);
      send(1'b0, 4'd7, 16'h0777, -1, 16'h0, o1);
      commit(1'b0, e);
      checks++;
      if (o1.lat !== 2 || o1.strobe !== 16'h0080 || o1.pend_after !== m_pend) begin
         failures++;
         $display("FAIL block_first got lat=%0d stb=%h pend=%h want lat=2 stb=0080 pend=%h",
                  o1.lat, o1.strobe, o1.pend_after, m_pend);
      end
      // Ack arrives in cycle 4 of the second offer, 5 cycles after the first strobe.
      send(1'b0, 4'd7, 16'h0778, 4, 16'h0080, o2);
      m_pend = m_pend & ~16'h0080;
      e = predict(1'b0, 4'd7, m_pend, m_ptr);
      commit(1'b0, e);
      checks++;
      if (o2.acc_idx !== 0 || o2.ready_hi !== 0) begin
         failures++;
         $display("FAIL block_wait_ready got acc=%0d ready_hi=%0d want acc=0 ready_hi=0",
                  o2.acc_idx, o2.ready_hi);
      end
      checks++;
      if (o2.lat !== 6 || o2.strobe !== (16'h0001 << e) || o2.strobe_data !== 16'h0778) begin
         failures++;
         $display("FAIL block_release got lat=%0d stb=%h data=%h want lat=6 stb=%h data=0778",
                  o2.lat, o2.strobe, o2.strobe_data, 16'h0001 << e);
      end
      checks++;
      if (o2.pend_after !== m_pend || o2.cnt_after !== 16'(m_cnt)) begin
         failures++;
         $display("FAIL block_state got pend=%h cnt=%h want pend=%h cnt=%h",
                  o2.pend_after, o2.cnt_after, m_pend, 16'(m_cnt));
      end
   endtask

   task automatic test_rr_skip();
      obs_t o;
      int   e;
      do_reset();
      send(1'b0, 4'd1, 16'h0001, -1, 16'h0, o);
      commit(1'b0, 1);
      send(1'b0, 4'd2, 16'h0002, -1, 16'h0, o);
      commit(1'b0, 2);
      checks++;
      if (o.pend_after !== 16'h0006) begin
         failures++; $display("FAIL rr_skip_preset got=%h want=0006", o.pend_after);
      end
      for (int w = 0; w < 3; w++) begin
         e = predict(1'b1, 4'h0, m_pend, m_ptr);
         send(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), -1, 16'h0, o);
         commit(1'b1, e);
         checks++;
         if (o.lat !== 2 || o.strobe !== (16'h0001 << e) || o.setup_sel !== 4'(e)) begin
            failures++;
            $display("FAIL rr_skip_word w=%0d got lat=%0d stb=%h sel=%h want lat=2 stb=%h sel=%h",
                     w, o.lat, o.strobe, o.setup_sel, 16'h0001 << e, 4'(e));
         end
      end
      checks++;
      if (dut.rr_ptr !== 4'(m_ptr)) begin
         failures++; $display("FAIL rr_skip_ptr got=%0d want=%0d", dut.rr_ptr, m_ptr);
      end
   endtask

   task automatic test_rr_full();
      obs_t o;
      int   e;
      do_reset();
      for (int w = 0; w < 16; w++) begin
         e = predict(1'b1, 4'h0, m_pend, m_ptr);
         send(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), -1, 16'h0, o);
         commit(1'b1, e);
         checks++;
         if (o.lat !== 2 || o.strobe !== (16'h0001 << e)) begin
            failures++;
            $display("FAIL rr_full_word w=%0d got lat=%0d stb=%h want lat=2 stb=%h",
                     w, o.lat, o.strobe, 16'h0001 << e);
         end
      end
      checks++;
      if (pending !== m_pend) begin
         failures++; $display("FAIL rr_full_pending got=%h want=%h", pending, m_pend);
      end
      // 17th word stalls until dest 10 is acked in cycle 4.
      send(1'b1, 4'h3, 16'hBEEF, 4, 16'h0400, o);
      m_pend = m_pend & ~16'h0400;
      e = predict(1'b1, 4'h0, m_pend, m_ptr);
      commit(1'b1, e);
      checks++;
      if (o.ready_hi !== 0 || o.lat !== 6) begin
         failures++;
         $display("FAIL rr_full_stall got ready_hi=%0d lat=%0d want ready_hi=0 lat=6",
                  o.ready_hi, o.lat);
      end
      checks++;
      if (o.strobe !== (16'h0001 << e) || o.strobe_data !== 16'hBEEF || o.pend_after !== m_pend) begin
         failures++;
         $display("FAIL rr_full_release got stb=%h data=%h pend=%h want stb=%h data=beef pend=%h",
                  o.strobe, o.strobe_data, o.pend_after, 16'h0001 << e, m_pend);
      end
   endtask

   task automatic test_set_ack_wrap();
      obs_t o;
      do_reset();
      force dut.count = 16'hFFFE;
      @(negedge clk);
      release dut.count;
      m_cnt = 16'hFFFE;
      @(negedge clk);
      checks++;
      if (delivered_count !== 16'(m_cnt)) begin
         failures++; $display("FAIL wrap_preload got=%h want=%h", delivered_count, 16'(m_cnt));
      end
      // Ack for dest 3 lands in its own strobe cycle; the set must win.
      send(1'b0, 4'd3, 16'h3333, 2, 16'h0008, o);
      commit(1'b0, 3);
      checks++;
      if (o.strobe !== 16'h0008 || o.pend_after !== m_pend) begin
         failures++;
         $display("FAIL set_ack_collide got stb=%h pend=%h want stb=0008 pend=%h",
                  o.strobe, o.pend_after, m_pend);
      end
      checks++;
      if (o.cnt_after !== 16'(m_cnt)) begin
         failures++; $display("FAIL wrap_ffff got=%h want=%h", o.cnt_after, 16'(m_cnt));
      end
      send(1'b0, 4'd4, 16'h4444, -1, 16'h0, o);
      commit(1'b0, 4);
      checks++;
      if (o.cnt_after !== 16'(m_cnt)) begin
         failures++; $display("FAIL wrap_zero got=%h want=%h", o.cnt_after, 16'(m_cnt));
      end
   endtask

   task automatic test_random();
      obs_t        o;
      int          e;
      logic        m;
      logic [3:0]  dst;
      logic [15:0] dat;
      logic [15:0] ack;
      do_reset();
      for (int w = 0; w < 40; w++) begin
         m   = 1'($urandom_range(0, 1));
         dst = 4'($urandom_range(0, 15));
         dat = 16'($urandom);
         ack = 16'($urandom & $urandom & $urandom);
         // Keep these words non-blocking; stalls are covered by directed tests.
         if (!m && (m_pend[dst] && !ack[dst])) ack = ack | (16'h0001 << dst);
         if (m && ((m_pend & ~ack) == 16'hFFFF)) ack = ack | (16'h0001 << $urandom_range(0, 15));
         pulse_ack(ack);
         m_pend = m_pend & ~ack;
         e = predict(m, dst, m_pend, m_ptr);
         send(m, dst, dat, -1, 16'h0, o);
         commit(m, e);
         checks++;
         if (o.lat !== 2 || o.strobe !== (16'h0001 << e) || o.setup_sel !== 4'(e)
             || o.setup_data !== dat || o.strobe_data !== dat) begin
            failures++;
            $display("FAIL random_word w=%0d m=%b got lat=%0d stb=%h sel=%h data=%h want lat=2 stb=%h sel=%h data=%h",
                     w, m, o.lat, o.strobe, o.setup_sel, o.strobe_data, 16'h0001 << e, 4'(e), dat);
         end
         checks++;
         if (o.pend_after !== m_pend || o.cnt_after !== 16'(m_cnt)) begin
            failures++;
            $display("FAIL random_state w=%0d got pend=%h cnt=%h want pend=%h cnt=%h",
                     w, o.pend_after, o.cnt_after, m_pend, 16'(m_cnt));
         end
      end
      checks++;
      if (dut.rr_ptr !== 4'(m_ptr)) begin
         failures++; $display("FAIL random_ptr got=%0d want=%0d", dut.rr_ptr, m_ptr);
      end
   endtask

   initial begin
      m_pend = 16'h0; m_ptr = 0; m_cnt = 0;
      test_reset();
      test_addressed_sweep();
      test_addressed_block();
      test_rr_skip();
      test_rr_full();
      test_set_ack_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/demux_16_sched.md
# demux_16_sched

Sequencing controller for the 16-bit 1-to-16 demultiplexer tree (1:2 first stage on `sel_4`, two 1:8 stages on `sel_1`..`sel_3`). It accepts 16-bit words over a valid/ready handshake and picks a destination, either addressed or round-robin. It holds `out_data` and the four selects stable, then pulses a one-hot strobe so only the chosen destination captures the word. Per-destination pending flags, cleared by `dest_ack`, stop a second word from overwriting an unconsumed one.

## Interface
- No parameters; all widths are fixed (16-bit data, 16 destinations).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word available.
- `in_ready`  out  1  controller can accept; a transfer occurs when `in_valid & in_ready` at a rising edge.
- `in_data`  in  16  word to distribute.
- `in_dest`  in  4  destination index 0..15; used only when `mode`=0.
- `mode`  in  1  0 = addressed, 1 = round-robin; sampled at accept.
- `dest_ack`  in  16  bit i clears pending flag i.
- `out_data`  out  16  drives the demux data input.
- `sel_1`, `sel_2`, `sel_3`, `sel_4`  out  1 each  demux selects: `sel_1`=d[0], `sel_2`=d[1], `sel_3`=d[2], `sel_4`=d[3]. Destination d maps to demux output d+1.
- `out_strobe`  out  16  one-hot capture pulse for destination d.
- `pending`  out  16  bit i = destination i holds an unacknowledged word.
- `delivered_count`  out  16  total strobes issued; wraps 0xFFFF→0x0000.

## Operation
- States: IDLE, WAIT, SETUP, STROBE.
- **IDLE**
  - `in_ready`=1.
  - On accept: latch `in_data`, `mode`, and `in_dest` (addressed mode).
  - Resolve destination d:
    - Addressed: d = `in_dest`.
    - Round-robin: d = first index not pending, searching from `rr_ptr` upward modulo 16.
  - If d is available: go to SETUP. Otherwise (addressed with d pending, or round-robin with all 16 pending): go to WAIT.
- **WAIT**
  - `in_ready`=0.
  - Each cycle, re-evaluate using the pending flags after this cycle's acks.
  - Addressed: leave when `pending[d]` clears.
  - Round-robin: when any flag clears, re-run the search from `rr_ptr`.
  - Then go to SETUP.
- **SETUP**
  - `out_data` and `sel_*` driven from d; settle cycle; no strobe.
- **STROBE**
  - `out_strobe[d]`=1 for exactly this cycle; `out_data` and `sel_*` held.
  - End of cycle: `pending[d]` set, `delivered_count`+1, `rr_ptr` = (d+1) mod 16 in round-robin mode only; next state IDLE.
- `out_data` and `sel_*` keep their last value in IDLE and WAIT; they change only on entry to SETUP.
- `dest_ack[i]` clears `pending[i]` in any state. An ack for a non-pending destination is ignored.
- Same-cycle set and ack on one bit: set wins. This occurs only if the ack arrives during the STROBE cycle of that destination.
- `pending` and `rr_ptr` are shared between modes. Switching mode between words is legal.

## Timing
- Reset values: state IDLE; `in_ready`=0 while `rst`=1; `out_data`=0, all `sel_*`=0, `out_strobe`=0, `pending`=0, `delivered_count`=0, `rr_ptr`=0.
- First cycle after `rst` deasserts: `in_ready`=1.
- Accept at edge N (not pending): SETUP in cycle N+1, strobe in cycle N+2, `in_ready`=1 in cycle N+3.
- Peak throughput: one word per 3 cycles.
- WAIT adds one cycle per cycle of blocking. Minimum latency from the clearing ack edge to the strobe is 2 cycles (SETUP, STROBE).
- `rst` in any state: the in-flight word is discarded with no strobe, all state returns to reset values, and pending flags are lost.
- `out_strobe` is never asserted in the same cycle as a change of `sel_*` or `out_data`.

## Test plan
- **Reset:** hold `rst` 3 cycles mid-STROBE with `in_dest`=5.
  - Required: `out_strobe`=0 from the next edge; all outputs zero; `in_ready`=1 one cycle after release.
- **Addressed sweep:** `mode`=0, `in_dest`=0..15, `in_data`=0xA000+d, `dest_ack[d]` pulsed right after each strobe.
  - Required: `sel_4..sel_1`=d and `out_data` stable one cycle before `out_strobe`=1<<d.
  - Required: 3-cycle spacing; `delivered_count`=16.
- **Addressed block:** send dest 7 twice with no ack; assert `dest_ack[7]` 5 cycles after the first strobe.
  - Required: second word waits in WAIT with `in_ready`=0; strobe 7 occurs 2 cycles after the ack; first strobe leaves `pending`=0x0080.
- **Round-robin skip:** preset `pending`=0x0006 via addressed words to dest 1 and 2, then `mode`=1 with 3 words.
  - Required: destinations 0, 3, 4 in that order; `rr_ptr`=5.
- **Round-robin full:** 16 round-robin words with no acks, then a 17th word, then `dest_ack`=0x0400.
  - Required: the 17th word stalls and is then delivered to destination 10.
- **Simultaneous set/ack and wrap:** ack dest 3 in its own STROBE cycle.
  - Required: `pending[3]` remains 1.
  - Preload `delivered_count` near 0xFFFF by long run or force; required: it wraps to 0x0000.
